// File: rtl/dqs_dll_pkg.sv
// Shared types and default sizing for the DQS quarter-period DLL controller.
package dqs_dll_pkg;
  localparam int CODE_W_DEF   = 7;
  localparam int SETTLE_DEF   = 4;
  localparam int LOSS_CNT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } dll_state_e;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } dll_dir_e;
endpackage

// File: rtl/dll_eval_timer.sv
// Settle counter: one eval strobe per SETTLE cycles; a frozen eval cycle is skipped.
module dll_eval_timer #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze,
  output logic eval_stb
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!freeze)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign eval_stb = (cnt == LAST) && !freeze;
endmodule

// File: rtl/dqs_dll_ctrl.sv
// DQS delay-lock controller: binary search then phase-detector tracking of a quarter-period code.
//   state  | meaning
//   IDLE   | wait one settle period, then seed the search at the code MSB
//   SEARCH | resolve one code bit per eval, MSB first
//   TRACK  | +/-1 per eval; a long one-directional run drops lock
module dqs_dll_ctrl
  import dqs_dll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int LOSS_CNT = LOSS_CNT_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              PD_UP,
  input  logic              FREEZE,
  input  logic              UDDCNTLN,
  output logic [CODE_W-1:0] DCNTL,
  output logic              LOCK,
  output logic              DQSDEL
);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int RUN_W = $clog2(LOSS_CNT + 1);
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  dll_state_e        state_q, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [RUN_W-1:0]  run_q, run_n;
  dll_dir_e          dir_q, dir_n;
  logic              lock_n;
  logic              eval_stb;

  dll_eval_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (CLK),
    .rst_n    (RSTN),
    .freeze   (FREEZE),
    .eval_stb (eval_stb)
  );

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    idx_n   = idx_q;
    run_n   = run_q;
    dir_n   = dir_q;
    lock_n  = LOCK;
    if (eval_stb) begin
      case (state_q)
        IDLE: begin
          code_n  = CODE_W'(1) << (CODE_W - 1);
          idx_n   = IDX_W'(CODE_W - 1);
          state_n = SEARCH;
        end
        SEARCH: begin
          if (!PD_UP)
            code_n[idx_q] = 1'b0;
          if (idx_q != '0) begin
            code_n[idx_q - 1'b1] = 1'b1;
            idx_n = idx_q - 1'b1;
          end else begin
            state_n = TRACK;
            lock_n  = 1'b1;
            run_n   = '0;
          end
        end
        TRACK: begin
          dir_n = PD_UP ? UP : DN;
          if (PD_UP && code_q != CODE_MAX)
            code_n = code_q + 1'b1;
          else if (!PD_UP && code_q != '0)
            code_n = code_q - 1'b1;
          // Saturated moves still extend the run so a pinned code eventually relocks.
          run_n = (run_q != '0 && dir_n == dir_q) ? run_q + 1'b1 : RUN_W'(1);
          if (run_n == RUN_W'(LOSS_CNT)) begin
            lock_n  = 1'b0;
            code_n  = '0;
            run_n   = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      dir_q   <= DN;
      LOCK    <= 1'b0;
      DQSDEL  <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      idx_q   <= idx_n;
      run_q   <= run_n;
      dir_q   <= dir_n;
      LOCK    <= lock_n;
      DQSDEL  <= lock_n;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      DCNTL <= '0;
    else if (!UDDCNTLN)
      DCNTL <= code_q;
  end
endmodule
